exc_redirect_ctrl: RTL and testbench

Pipeline-side consumer of the CP0 exception interface. It takes CP0's exception report (exc code, EPC) and eret request, flushes the affected pipeline stages for a fixed window, then issues a valid/ready PC redirect to fetch. The target is the exception vector for exceptions and EPC for eret. It also tracks whether the core is inside a handler and counts requests refused while busy.

---
 rtl/exc_redirect_if.sv | 24 ++
 rtl/exc_redirect_ctrl.sv | 90 +++++++++
 tb/tb_exc_redirect_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/exc_redirect_if.sv
// exc_redirect_if: signal bundle between CP0/fetch and exc_redirect_ctrl
//   master (CP0 + fetch): drives exc, eret, epc, pause, pc_ready
//   slave  (controller) : drives flush, redirect_valid, redirect_pc, busy, in_handler, drop_cnt
interface exc_redirect_if #(parameter int unsigned CNT_W = 8);
    logic [1:0]       exc;
    logic             eret;
    logic [31:0]      epc;
    logic             pause;
    logic             pc_ready;
    logic [3:0]       flush;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             busy;
    logic             in_handler;
    logic [CNT_W-1:0] drop_cnt;
    modport master (
        output exc, eret, epc, pause, pc_ready,
        input  flush, redirect_valid, redirect_pc, busy, in_handler, drop_cnt
    );
    modport slave (
        input  exc, eret, epc, pause, pc_ready,
        output flush, redirect_valid, redirect_pc, busy, in_handler, drop_cnt
    );
endinterface

// File: rtl/exc_redirect_ctrl.sv
// exc_redirect_ctrl: flushes the pipeline after a CP0 exception/eret, then redirects fetch
//   clk, rst       : clock, asynchronous active-high reset
//   bus.exc/eret/epc: CP0 exception report and return request (EPC used for eret)
//   bus.pause       : pipeline stall, freezes request sampling and the flush window
//   bus.pc_ready    : fetch accepts the redirect
//   bus.flush       : per-stage flush {MEM, EX, ID, IF}
//   bus.redirect_*  : valid/ready redirect offer and its target
//   bus.busy, bus.in_handler, bus.drop_cnt: status outputs (all registered)
module exc_redirect_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 8
) (
    input logic           clk,
    input logic           rst,
    exc_redirect_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, FLUSH = 2'd1, REDIRECT = 2'd2;
    logic [1:0]       r_state, w_state;
    logic [3:0]       r_cnt, w_cnt;
    logic [31:0]      r_target, w_target;
    logic [3:0]       r_mask, w_mask;
    logic             r_is_exc, w_is_exc;
    logic             r_in_handler, w_in_handler;
    logic [CNT_W-1:0] r_drop, w_drop;
    logic [3:0]       r_flush, w_flush;
    logic             r_valid, w_valid;
    logic [31:0]      r_pc, w_pc;
    logic             r_busy, w_busy;
    logic             w_exc, w_req, w_take, w_run, w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_target     <= 32'd0;
            r_mask       <= 4'd0;
            r_is_exc     <= 1'b0;
            r_in_handler <= 1'b0;
            r_drop       <= '0;
            r_flush      <= 4'd0;
            r_valid      <= 1'b0;
            r_pc         <= 32'd0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_target     <= w_target;
            r_mask       <= w_mask;
            r_is_exc     <= w_is_exc;
            r_in_handler <= w_in_handler;
            r_drop       <= w_drop;
            r_flush      <= w_flush;
            r_valid      <= w_valid;
            r_pc         <= w_pc;
            r_busy       <= w_busy;
        end
    end

    // Exception beats eret when both arrive; requests seen while busy are only counted.
    always_comb begin
        w_exc        = |bus.exc;
        w_req        = w_exc || bus.eret;
        w_take       = r_state == IDLE && !bus.pause && w_req;
        w_run        = r_state == FLUSH && !bus.pause;
        w_done       = r_state == REDIRECT && bus.pc_ready;
        w_state      = w_take ? FLUSH : (w_run && r_cnt == 4'd1) ? REDIRECT : w_done ? IDLE : r_state;
        w_cnt        = w_take ? 4'(FLUSH_CYCLES) : w_run ? r_cnt - 4'd1 : r_cnt;
        w_target     = w_take ? (w_exc ? EXC_VECTOR : bus.epc) : r_target;
        w_mask       = w_take ? (w_exc ? 4'b1111 : 4'b0011) : r_mask;
        w_is_exc     = w_take ? w_exc : r_is_exc;
        w_in_handler = w_done ? r_is_exc : r_in_handler;
        w_drop       = (r_state != IDLE && !bus.pause && w_req && r_drop != '1) ? r_drop + CNT_W'(1) : r_drop;
    end

    // Outputs are computed from the next state so they can be registered alongside it.
    always_comb begin
        w_busy  = w_state != IDLE;
        w_flush = w_state == FLUSH ? w_mask : 4'd0;
        w_valid = w_state == REDIRECT;
        w_pc    = w_valid ? w_target : 32'd0;
    end

    assign bus.flush          = r_flush;
    assign bus.redirect_valid = r_valid;
    assign bus.redirect_pc    = r_pc;
    assign bus.busy           = r_busy;
    assign bus.in_handler     = r_in_handler;
    assign bus.drop_cnt       = r_drop;
endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// tb_exc_redirect_ctrl: scoreboard bench for exc_redirect_ctrl with a transaction-level model
module tb_exc_redirect_ctrl;
    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam int F = 2;
    localparam int SAT = 255;
    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  mask;
        logic        is_exc;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    item_t exp_q[$];
    item_t cur;
    int m_mode, m_left, m_drop;
    logic m_inh;
    logic [3:0] e_flush;
    logic e_valid, e_busy;

    exc_redirect_if ifc ();
    exc_redirect_ctrl dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted request owns F unpaused flush cycles, then waits for pc_ready.
    always @(posedge clk or posedge rst) begin
        logic ex, req;
        if (rst) begin
            m_mode = 0;
            m_left = 0;
            m_drop = 0;
            m_inh  = 1'b0;
            cur    = '0;
            exp_q.delete();
        end else begin
            ex  = ifc.exc != 2'd0;
            req = ex || ifc.eret;
            if (m_mode == 0) begin
                if (!ifc.pause && req) begin
                    cur = '{pc: ex ? VEC : ifc.epc, mask: ex ? 4'hF : 4'h3, is_exc: ex};
                    exp_q.push_back(cur);
                    m_left = F;
                    m_mode = 1;
                end
            end else begin
                if (!ifc.pause && req && m_drop < SAT) m_drop++;
                if (m_mode == 1) begin
                    if (!ifc.pause) m_left--;
                    if (m_left == 0) m_mode = 2;
                end else if (ifc.pc_ready) begin
                    m_inh  = cur.is_exc;
                    m_mode = 0;
                end
            end
        end
        e_busy  = m_mode != 0;
        e_flush = m_mode == 1 ? cur.mask : 4'h0;
        e_valid = m_mode == 2;
    end

    always @(negedge clk) begin
        item_t it;
        chk("busy", ifc.busy, e_busy);
        chk("flush", ifc.flush, e_flush);
        chk("redirect_valid", ifc.redirect_valid, e_valid);
        if (e_valid) chk("redirect_pc", ifc.redirect_pc, cur.pc);
        chk("in_handler", ifc.in_handler, m_inh);
        chk("drop_cnt", ifc.drop_cnt, m_drop);
        if (ifc.flush != 4'h0 && exp_q.size() != 0) chk("sb_mask", ifc.flush, exp_q[0].mask);
        if (ifc.redirect_valid && ifc.pc_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: redirect to %h with no expected entry", ifc.redirect_pc);
            end else begin
                it = exp_q.pop_front();
                chk("sb_pc", ifc.redirect_pc, it.pc);
            end
        end
    end

    task automatic step(input logic [1:0] e, input logic r, input logic [31:0] p,
                        input logic ps, input logic rdy, input int n = 1);
        ifc.exc = e;
        ifc.eret = r;
        ifc.epc = p;
        ifc.pause = ps;
        ifc.pc_ready = rdy;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        ifc.exc = 2'd0;
        ifc.eret = 1'b0;
        ifc.epc = 32'd0;
        ifc.pause = 1'b0;
        ifc.pc_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step(2'd0, 1'b0, 32'd0, 1'b0, 1'b1, 2);
        // exception redirect
        step(2'd1, 1'b0, 32'd0, 1'b0, 1'b1);
        step(2'd0, 1'b0, 32'd0, 1'b0, 1'b1, 6);
        // eret back out of the handler
        step(2'd0, 1'b1, 32'hBFC00704, 1'b0, 1'b1);
        step(2'd0, 1'b0, 32'd0, 1'b0, 1'b1, 6);
        // stall during flush, then fetch holds off
        step(2'd1, 1'b0, 32'd0, 1'b0, 1'b0);
        step(2'd0, 1'b0, 32'd0, 1'b1, 1'b0, 3);
        step(2'd0, 1'b0, 32'd0, 1'b0, 1'b0, 6);
        step(2'd0, 1'b0, 32'd0, 1'b0, 1'b1, 3);
        // simultaneous delay-slot exception and eret
        step(2'd2, 1'b1, 32'h12345678, 1'b0, 1'b1);
        step(2'd0, 1'b0, 32'd0, 1'b0, 1'b1, 6);
        // drop saturation, then paused request in idle
        step(2'd1, 1'b0, 32'd0, 1'b0, 1'b0);
        step(2'd1, 1'b0, 32'd0, 1'b0, 1'b0, 300);
        step(2'd0, 1'b0, 32'd0, 1'b0, 1'b1, 4);
        step(2'd1, 1'b0, 32'd0, 1'b1, 1'b1, 5);
        step(2'd0, 1'b0, 32'd0, 1'b0, 1'b1, 3);
        // asynchronous reset in the middle of a flush
        step(2'd1, 1'b0, 32'd0, 1'b0, 1'b1);
        ifc.exc = 2'd0;
        #2 rst = 1'b1;
        #1;
        chk("rst_flush", ifc.flush, 32'd0);
        chk("rst_valid", ifc.redirect_valid, 32'd0);
        chk("rst_busy", ifc.busy, 32'd0);
        chk("rst_drop", ifc.drop_cnt, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(2'd0, 1'b0, 32'd0, 1'b0, 1'b1, 3);
        step(2'd1, 1'b0, 32'd0, 1'b0, 1'b1);
        step(2'd0, 1'b0, 32'd0, 1'b0, 1'b1, 6);
        // random traffic
        repeat (1500) begin
            step(($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                 $urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
        end
        step(2'd0, 1'b0, 32'd0, 1'b0, 1'b1, 20);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
